multi_channel_trigger_sequencer: RTL and testbench
==================================================

// Module: multi_channel_trigger_sequencer
// PURPOSE
//  Multi-channel successor to the single-channel coarse trigger delay. One pre-synchronised trigger
//  pulse fans out to NUM_CH independent channels. Each channel emits a programmable burst:
//  delay, then N pulses of width W separated by gap G. Config is double-buffered (shadow -> active).
//  Sits after CDC/edge detect; drives glitch outputs or per-channel fine-delay stages.
// PARAMETERS
//  NUM_CH   4   number of output channels (1..16)
//  DELAY_W  32  width of delay/width/gap fields and cfg_wdata
//  COUNT_W  8   width of burst pulse count
//  TS_W     32  timestamp width (used only with TRIG_TIMESTAMP_EN)
// PORTS
//  clk          in   1              single clock; all logic rising-edge
//  rst_n        in   1              synchronous reset, active-low
//  trig_pulse   in   1              1-cycle trigger, already synchronised/edge-detected
//  arm          in   NUM_CH         per-channel level enable for trigger acceptance
//  abort        in   NUM_CH         per-channel 1-cycle kill of running sequence
//  cfg_we       in   1              write cfg_wdata to shadow field of cfg_ch
//  cfg_ch       in   CH_W           channel select; CH_W = max(1, $clog2(NUM_CH))
//  cfg_addr     in   2              0 = delay D, 1 = width W, 2 = gap G, 3 = count N (low COUNT_W bits)
//  cfg_wdata    in   DELAY_W        write data
//  cfg_commit   in   NUM_CH         per-channel request to copy shadow -> active
//  miss_clr     in   NUM_CH         clear sticky missed flag
//  trig_out     out  NUM_CH         registered burst outputs
//  busy         out  NUM_CH         channel not IDLE
//  done         out  NUM_CH         1-cycle pulse at burst completion
//  missed       out  NUM_CH         sticky: trigger arrived while armed and busy
//  commit_pend  out  NUM_CH         commit requested, not yet applied
// BEHAVIOUR
//  - Reset (rst_n = 0 at an edge): all outputs 0; FSMs in IDLE; shadow and active config = D0/W1/G1/N1.
//    Reset mid-burst drops trig_out the next cycle.
//  - Per-channel FSM states: IDLE -> DELAY -> PULSE -> GAP -> PULSE ... -> IDLE.
//  - Accept: trig_pulse = 1 at cycle T, channel IDLE, arm = 1. Active config is snapshotted at T.
//  - Timing: trig_out is first high at T+1+D (D = 0 gives T+1). It stays high W cycles, then low
//    G cycles between pulses, for N pulses total.
//  - W = 0, G = 0 and N = 0 are each treated as 1. Counters are DELAY_W/COUNT_W wide; no overflow.
//  - Completion: the cycle after the last high cycle, trig_out = 0, done = 1, busy = 0, state = IDLE.
//    A trig_pulse in that cycle is accepted (back-to-back bursts).
//  - The DELAY/GAP states are skipped when unused; D = 0 means no DELAY cycles.
//  - trig_pulse while busy and armed: ignored; missed set next cycle. If set and miss_clr coincide,
//    set wins. trig_pulse while disarmed: ignored, missed not set.
//  - arm dropping mid-burst does not stop the burst.
//  - abort: next cycle IDLE, trig_out = 0, busy = 0, no done. Pending commit preserved.
//    Abort with an accept in the same cycle: abort wins, nothing starts.
//  - cfg_we: writes shadow at any time, 1-cycle latency; never affects a running burst.
//  - cfg_commit[i]: sets commit_pend[i]. Shadow -> active is copied in the first cycle channel i is
//    IDLE and not accepting a trigger; commit_pend clears the same edge.
//  - Commit and trigger in the same IDLE cycle: the trigger uses the old active config; the copy
//    happens when the channel is next IDLE. Shadow writes in the commit cycle are included.
//  - Channels are fully independent; all outputs are registered; no combinational input->output path.
// CONFIGURATION
//  TRIG_TIMESTAMP_EN defined:
//   - Adds a free-running TS_W counter (0 after reset, wraps to 0).
//   - Adds output port ts_out (NUM_CH*TS_W) and output ts_valid (NUM_CH).
//   - On accept at cycle T, channel i latches the counter value at T into ts_out slice i.
//     ts_valid[i] pulses for 1 cycle at T+1.
//  TRIG_TIMESTAMP_EN not defined: no counter, no ts_out/ts_valid ports; all other behaviour identical.
// TESTING
//  1. Reset, ch0 D=5 W=3 G=2 N=2, commit, arm=1, pulse at T -> ch0 high T+6..T+8 and T+11..T+13;
//     done at T+14.
//  2. Defaults (D0/W1/G1/N1), pulse at T -> trig_out high only at T+1; done at T+2.
//  3. D=10 burst running, second pulse at T+4 -> ignored; missed=1 from T+5.
//     miss_clr together with a new miss -> missed stays 1.
//  4. Commit D=20 in the same cycle as an accept with D=3 -> first burst uses D=3;
//     commit_pend clears when IDLE; next burst uses D=20.
//  5. abort at mid-pulse -> trig_out=0, busy=0 next cycle, no done; next trigger accepted normally.
//  6. TRIG_TIMESTAMP_EN: pulse at counter value 100 on ch0 and ch2 -> both ts_out slices = 100,
//     ts_valid at T+1; disarmed ch1 has no ts_valid.

Source files
------------

// File: rtl/multi_channel_trigger_sequencer.sv
// ----------------------------------------------------------------------------
// multi_channel_trigger_sequencer
//
// Purpose:
//   Fans one pre-synchronised trigger pulse out to NUM_CH independent channels.
//   Each armed, idle channel that sees the trigger plays a burst from its
//   active configuration: D delay cycles, then N pulses of W high cycles
//   separated by G low cycles. Configuration is double-buffered. cfg_we writes
//   a shadow field, and cfg_commit requests a shadow -> active copy. The copy
//   is applied only while the channel is idle.
//
// Optional feature (macro TRIG_TIMESTAMP_EN):
//   Adds a free-running TS_W-bit counter, the ts_out and ts_valid ports, and a
//   per-channel capture of the counter value in the accept cycle.
//
// Ports:
//   clk          in   single rising-edge clock
//   rst_n        in   synchronous reset, active-low
//   trig_pulse   in   1-cycle trigger (already synchronised / edge-detected)
//   arm          in   [NUM_CH]  per-channel trigger acceptance enable (level)
//   abort        in   [NUM_CH]  per-channel kill of a running burst
//   cfg_we       in   write cfg_wdata into shadow field cfg_addr of channel cfg_ch
//   cfg_ch       in   [CH_W]    channel select
//   cfg_addr     in   [2]       0 delay, 1 width, 2 gap, 3 count (low COUNT_W bits)
//   cfg_wdata    in   [DELAY_W] write data
//   cfg_commit   in   [NUM_CH]  request shadow -> active copy
//   miss_clr     in   [NUM_CH]  clear sticky missed flag
//   trig_out     out  [NUM_CH]  registered burst outputs
//   busy         out  [NUM_CH]  channel not idle
//   done         out  [NUM_CH]  1-cycle pulse at burst completion
//   missed       out  [NUM_CH]  sticky: trigger seen while armed and busy
//   commit_pend  out  [NUM_CH]  commit requested, not yet applied
//   ts_out       out  [NUM_CH*TS_W] accept timestamps (TRIG_TIMESTAMP_EN only)
//   ts_valid     out  [NUM_CH]  1-cycle pulse after accept (TRIG_TIMESTAMP_EN only)
// ----------------------------------------------------------------------------
module multi_channel_trigger_sequencer #(
    parameter int unsigned  NUM_CH  = 4,
    parameter int unsigned  DELAY_W = 32,
    parameter int unsigned  COUNT_W = 8,
    parameter int unsigned  TS_W    = 32,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trig_pulse,
    input  logic [NUM_CH-1:0]    arm,
    input  logic [NUM_CH-1:0]    abort,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_addr,
    input  logic [DELAY_W-1:0]   cfg_wdata,
    input  logic [NUM_CH-1:0]    cfg_commit,
    input  logic [NUM_CH-1:0]    miss_clr,
    output logic [NUM_CH-1:0]    trig_out,
    output logic [NUM_CH-1:0]    busy,
    output logic [NUM_CH-1:0]    done,
    output logic [NUM_CH-1:0]    missed,
`ifdef TRIG_TIMESTAMP_EN
    output logic [NUM_CH-1:0]    commit_pend,
    output logic [NUM_CH*TS_W-1:0] ts_out,
    output logic [NUM_CH-1:0]    ts_valid
`else
    output logic [NUM_CH-1:0]    commit_pend
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StPulse = 2'd2,
        StGap   = 2'd3
    } state_e;

    // Elaboration-time parameter sanity check.
    if (NUM_CH < 1 || NUM_CH > 16 || COUNT_W > DELAY_W || TS_W < 1) begin : g_param_check
        $error("multi_channel_trigger_sequencer: unsupported parameter set");
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_e             state_q, state_d;
        logic [DELAY_W-1:0] cnt_q, cnt_d;      // cycles left in current phase, incl. this one
        logic [COUNT_W-1:0] left_q, left_d;    // pulses left, incl. the current one

        logic [DELAY_W-1:0] sh_dly_q, sh_dly_d, sh_wid_q, sh_wid_d, sh_gap_q, sh_gap_d;
        logic [COUNT_W-1:0] sh_num_q, sh_num_d;
        logic [DELAY_W-1:0] act_dly_q, act_dly_d, act_wid_q, act_wid_d, act_gap_q, act_gap_d;
        logic [COUNT_W-1:0] act_num_q, act_num_d;

        logic pend_q, pend_d;
        logic missed_q, missed_d;
        logic trig_q, trig_d;
        logic busy_q, busy_d;
        logic done_q, done_d;

        logic               sel;
        logic               accept;
        logic               copy;
        logic [DELAY_W-1:0] wid_eff, gap_eff;
        logic [COUNT_W-1:0] num_eff;

        // Active config can only change while idle, so it is stable for the
        // whole burst; it serves as the accept-time snapshot without extra flops.
        always_comb begin
            sel     = cfg_we && (cfg_ch == CH_W'(gi));
            accept  = trig_pulse && arm[gi] && (state_q == StIdle) && !abort[gi];
            copy    = pend_q && (state_q == StIdle) && !accept;
            wid_eff = (act_wid_q == '0) ? DELAY_W'(1) : act_wid_q;
            gap_eff = (act_gap_q == '0) ? DELAY_W'(1) : act_gap_q;
            num_eff = (act_num_q == '0) ? COUNT_W'(1) : act_num_q;
        end

        // Shadow / active configuration and commit handshake.
        always_comb begin
            sh_dly_d  = sh_dly_q;
            sh_wid_d  = sh_wid_q;
            sh_gap_d  = sh_gap_q;
            sh_num_d  = sh_num_q;
            act_dly_d = act_dly_q;
            act_wid_d = act_wid_q;
            act_gap_d = act_gap_q;
            act_num_d = act_num_q;
            if (sel) begin
                case (cfg_addr)
                    2'd0:    sh_dly_d = cfg_wdata;
                    2'd1:    sh_wid_d = cfg_wdata;
                    2'd2:    sh_gap_d = cfg_wdata;
                    default: sh_num_d = cfg_wdata[COUNT_W-1:0];
                endcase
            end
            if (copy) begin
                act_dly_d = sh_dly_q;
                act_wid_d = sh_wid_q;
                act_gap_d = sh_gap_q;
                act_num_d = sh_num_q;
            end
            // A new request in the copy cycle keeps the flag set.
            pend_d = (pend_q && !copy) || cfg_commit[gi];
        end

        // Burst sequencer.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            left_d  = left_q;
            done_d  = 1'b0;
            if (abort[gi]) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            left_d = num_eff;
                            if (act_dly_q == '0) begin
                                state_d = StPulse;
                                cnt_d   = wid_eff;
                            end else begin
                                state_d = StDelay;
                                cnt_d   = act_dly_q;
                            end
                        end
                    end
                    StDelay: begin
                        if (cnt_q <= DELAY_W'(1)) begin
                            state_d = StPulse;
                            cnt_d   = wid_eff;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                    StPulse: begin
                        if (cnt_q <= DELAY_W'(1)) begin
                            if (left_q <= COUNT_W'(1)) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else begin
                                state_d = StGap;
                                cnt_d   = gap_eff;
                                left_d  = left_q - COUNT_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                    StGap: begin
                        if (cnt_q <= DELAY_W'(1)) begin
                            state_d = StPulse;
                            cnt_d   = wid_eff;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
            // Outputs are registered copies of the next state.
            trig_d   = (state_d == StPulse);
            busy_d   = (state_d != StIdle);
            // Set has priority over clear.
            missed_d = (trig_pulse && arm[gi] && (state_q != StIdle)) ||
                       (missed_q && !miss_clr[gi]);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                left_q    <= '0;
                sh_dly_q  <= '0;
                sh_wid_q  <= DELAY_W'(1);
                sh_gap_q  <= DELAY_W'(1);
                sh_num_q  <= COUNT_W'(1);
                act_dly_q <= '0;
                act_wid_q <= DELAY_W'(1);
                act_gap_q <= DELAY_W'(1);
                act_num_q <= COUNT_W'(1);
                pend_q    <= 1'b0;
                missed_q  <= 1'b0;
                trig_q    <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                left_q    <= left_d;
                sh_dly_q  <= sh_dly_d;
                sh_wid_q  <= sh_wid_d;
                sh_gap_q  <= sh_gap_d;
                sh_num_q  <= sh_num_d;
                act_dly_q <= act_dly_d;
                act_wid_q <= act_wid_d;
                act_gap_q <= act_gap_d;
                act_num_q <= act_num_d;
                pend_q    <= pend_d;
                missed_q  <= missed_d;
                trig_q    <= trig_d;
                busy_q    <= busy_d;
                done_q    <= done_d;
            end
        end

        assign trig_out[gi]    = trig_q;
        assign busy[gi]        = busy_q;
        assign done[gi]        = done_q;
        assign missed[gi]      = missed_q;
        assign commit_pend[gi] = pend_q;

`ifdef TRIG_TIMESTAMP_EN
        logic [TS_W-1:0] ts_q, ts_d;
        logic            tsv_q, tsv_d;

        always_comb begin
            ts_d  = accept ? ts_cnt_q : ts_q;
            tsv_d = accept;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ts_q  <= '0;
                tsv_q <= 1'b0;
            end else begin
                ts_q  <= ts_d;
                tsv_q <= tsv_d;
            end
        end

        assign ts_out[gi*TS_W +: TS_W] = ts_q;
        assign ts_valid[gi]            = tsv_q;
`endif
    end

endmodule

// File: tb/tb_multi_channel_trigger_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multi_channel_trigger_sequencer
//
// Self-checking bench: a table of single-cycle vectors (inputs and expected
// outputs one edge later), followed by hand-written multi-cycle sequences for
// long bursts, missed-trigger handling, commit timing and abort. The
// timestamp check is compiled only when TRIG_TIMESTAMP_EN is defined.
// ----------------------------------------------------------------------------
module tb_multi_channel_trigger_sequencer;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            trig_pulse = 1'b0;
    logic [NCH-1:0]  arm = '0;
    logic [NCH-1:0]  abort = '0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_ch = '0;
    logic [1:0]      cfg_addr = '0;
    logic [DW-1:0]   cfg_wdata = '0;
    logic [NCH-1:0]  cfg_commit = '0;
    logic [NCH-1:0]  miss_clr = '0;
    logic [NCH-1:0]  trig_out, busy, done, missed, commit_pend;
`ifdef TRIG_TIMESTAMP_EN
    logic [NCH*TW-1:0] ts_out;
    logic [NCH-1:0]    ts_valid;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_channel_trigger_sequencer #(
        .NUM_CH  (NCH),
        .DELAY_W (DW),
        .COUNT_W (8),
        .TS_W    (TW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_pulse  (trig_pulse),
        .arm         (arm),
        .abort       (abort),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .miss_clr    (miss_clr),
        .trig_out    (trig_out),
        .busy        (busy),
        .done        (done),
        .missed      (missed),
`ifdef TRIG_TIMESTAMP_EN
        .commit_pend (commit_pend),
        .ts_out      (ts_out),
        .ts_valid    (ts_valid)
`else
        .commit_pend (commit_pend)
`endif
    );

    typedef struct {
        logic           rst;
        logic           trig;
        logic [NCH-1:0] arm;
        logic [NCH-1:0] abrt;
        logic [NCH-1:0] mclr;
        logic [NCH-1:0] et;
        logic [NCH-1:0] eb;
        logic [NCH-1:0] ed;
        logic [NCH-1:0] em;
    } vec_t;

    localparam int NV = 14;
    vec_t  vt    [NV];
    string vname [NV];

    // Advance one clock; outputs are sampled 1 time unit after the edge and
    // single-cycle inputs return to 0.
    task automatic cyc();
        @(posedge clk);
        #1;
        trig_pulse = 1'b0;
        abort      = '0;
        cfg_we     = 1'b0;
        cfg_commit = '0;
        miss_clr   = '0;
    endtask

    task automatic wr(input int ch, input int a, input int d);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_addr  = 2'(a);
        cfg_wdata = DW'(d);
        cyc();
    endtask

    task automatic chk(input string nm, input logic [NCH-1:0] et, input logic [NCH-1:0] eb,
                       input logic [NCH-1:0] ed, input logic [NCH-1:0] em,
                       input logic [NCH-1:0] ep);
        logic [5*NCH-1:0] got, exp;
        got = {trig_out, busy, done, missed, commit_pend};
        exp = {et, eb, ed, em, ep};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got trig=%b busy=%b done=%b missed=%b pend=%b, want trig=%b busy=%b done=%b missed=%b pend=%b",
                     nm, trig_out, busy, done, missed, commit_pend, et, eb, ed, em, ep);
        end
    endtask

    initial begin
        // rst trig arm abort mclr | trig_out busy done missed
        vt[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[2]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vt[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vt[4]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[5]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[6]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        vt[7]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
        vt[8]  = '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b1100, 4'b0011, 4'b0011, 4'b0000, 4'b0011};
        vt[9]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0001};
        vt[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[11] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[12] = '{1'b1, 1'b1, 4'b0010, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        vt[13] = '{1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vname = '{"reset", "idle", "def_accept", "def_done", "def_quiet", "disarmed_ignored",
                  "all_accept", "busy_miss_all", "miss_clr_partial", "miss_set_beats_clr",
                  "miss_clr", "abort_beats_accept", "ch1_accept", "abort_mid_pulse"};

        for (int i = 0; i < NV; i++) begin
            rst_n      = vt[i].rst;
            trig_pulse = vt[i].trig;
            arm        = vt[i].arm;
            abort      = vt[i].abrt;
            miss_clr   = vt[i].mclr;
            cyc();
            chk(vname[i], vt[i].et, vt[i].eb, vt[i].ed, vt[i].em, 4'b0000);
        end

        // D=5 W=3 G=2 N=2 on ch0: high T+6..8 and T+11..13, done T+14.
        arm = 4'b0001;
        wr(0, 0, 5);
        wr(0, 1, 3);
        wr(0, 2, 2);
        wr(0, 3, 2);
        cfg_commit = 4'b0001;
        cyc();
        chk("a_pend_set", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        cyc();
        chk("a_pend_clr", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        trig_pulse = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk($sformatf("a_burst_t%0d", k),
                {3'b000, ((k >= 6 && k <= 8) || (k >= 11 && k <= 13))},
                {3'b000, (k <= 13)}, {3'b000, (k == 14)}, 4'b0000, 4'b0000);
        end

        // D=10 W=1 N=1: retrigger at T+4 missed, set beats clear at T+6.
        wr(0, 0, 10);
        wr(0, 1, 1);
        wr(0, 2, 1);
        wr(0, 3, 1);
        cfg_commit = 4'b0001;
        cyc();
        cyc();
        for (int k = 0; k <= 12; k++) begin
            trig_pulse = (k == 0 || k == 4 || k == 6);
            miss_clr   = {3'b000, (k == 6 || k == 8)};
            cyc();
            chk($sformatf("b_miss_t%0d", k + 1),
                {3'b000, (k + 1 == 11)}, {3'b000, (k + 1 <= 11)}, {3'b000, (k + 1 == 12)},
                {3'b000, (k + 1 >= 5 && k + 1 <= 8)}, 4'b0000);
        end

        // Commit D=20 alongside an accept that must still use D=3.
        wr(0, 0, 3);
        cfg_commit = 4'b0001;
        cyc();
        cyc();
        trig_pulse = 1'b1;
        cfg_commit = 4'b0001;
        cfg_we     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_addr   = 2'd0;
        cfg_wdata  = DW'(20);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("c_first_t%0d", k), {3'b000, (k == 4)}, {3'b000, (k <= 4)},
                {3'b000, (k == 5)}, 4'b0000, {3'b000, (k <= 5)});
        end
        trig_pulse = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            chk($sformatf("c_second_t%0d", k), {3'b000, (k == 21)}, {3'b000, (k <= 21)},
                {3'b000, (k == 22)}, 4'b0000, 4'b0000);
        end

        // ch3 W=4: abort during the pulse, pending commit survives the abort.
        arm = 4'b1000;
        wr(3, 1, 4);
        cfg_commit = 4'b1000;
        cyc();
        cyc();
        for (int k = 0; k <= 4; k++) begin
            trig_pulse = (k == 0);
            cfg_commit = {(k == 1), 3'b000};
            abort      = {(k == 2), 3'b000};
            cyc();
            chk($sformatf("d_abort_t%0d", k + 1), {(k + 1 <= 2), 3'b000}, {(k + 1 <= 2), 3'b000},
                4'b0000, 4'b0000, {(k + 1 == 2 || k + 1 == 3), 3'b000});
        end
        trig_pulse = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("d_retrig_t%0d", k), {(k <= 4), 3'b000}, {(k <= 4), 3'b000},
                {(k == 5), 3'b000}, 4'b0000, 4'b0000);
        end

`ifdef TRIG_TIMESTAMP_EN
        // Counter reads 0 in the cycle after the last reset edge, 100 after 100 more edges.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (100) cyc();
        arm        = 4'b0101;
        trig_pulse = 1'b1;
        cyc();
        n_vec++;
        if (ts_valid !== 4'b0101 || ts_out[31:0] !== 32'd100 || ts_out[95:64] !== 32'd100) begin
            n_bad++;
            $display("FAIL ts_capture: got valid=%b ts0=%0d ts2=%0d, want valid=0101 ts0=100 ts2=100",
                     ts_valid, ts_out[31:0], ts_out[95:64]);
        end
        cyc();
        n_vec++;
        if (ts_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL ts_valid_pulse: got valid=%b, want 0000", ts_valid);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
